// File: rtl/synth_audio_pkg.sv
// Audio output constants and types shared by the synth engine's output stage.
package synth_audio_pkg;

    localparam int I2S_SLOT_W  = 32;
    localparam int I2S_BCK_DIV = 3;
    localparam int I2S_DATA_W  = 16;

    localparam logic [7:0] UNDERRUN_MAX = 8'd255;

    typedef struct packed {
        logic [I2S_DATA_W-1:0] left;
        logic [I2S_DATA_W-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/utils.sv
// Shared elaboration-time helpers.
package utils;

    // Bits needed to hold the values 0..value-1; never narrower than one bit.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Stereo sample handshake between the mixer and the I2S transmitter.
interface i2s_dac_tx_if #(
    parameter int DATA_W = 16
);
    logic              sample_valid;
    logic              sample_ready;
    logic [DATA_W-1:0] lsample;
    logic [DATA_W-1:0] rsample;

    modport master (
        output sample_valid,
        output lsample,
        output rsample,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  lsample,
        input  rsample,
        output sample_ready
    );
endinterface

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: BCK toggles every BCK_DIV clocks; fall_tick marks the 1->0 edge.
module i2s_bck_gen #(
    parameter int BCK_DIV = 3
) (
    input  logic clk,
    input  logic rst_n,
    output logic bck,
    output logic fall_tick
);

    localparam int                 DIV_W    = utils::clogb2(BCK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(BCK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bck_q, bck_d;
    logic             wrap;

    always_comb begin
        wrap      = (div_cnt_q == DIV_LAST);
        div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
        bck_d     = wrap ? ~bck_q : bck_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bck_q     <= bck_d;
        end
    end

    assign bck       = bck_q;
    assign fall_tick = wrap & bck_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter: double-buffers one stereo pair per frame and serialises it
// MSB-first with the standard one-BCK delay after each LRCK transition.
module i2s_dac_tx
    import synth_audio_pkg::*;
#(
    parameter int DATA_W  = I2S_DATA_W,
    parameter int SLOT_W  = I2S_SLOT_W,
    parameter int BCK_DIV = I2S_BCK_DIV
) (
    input  logic          AUDIO_CLK,
    input  logic          iRST_N,
    i2s_dac_tx_if.slave   smp,
    output logic          AUD_BCK,
    output logic          AUD_LRCK,
    output logic          AUD_DATA,
    output logic          frame_start,
    output logic [7:0]    underrun_cnt
);

    localparam int               FRAME_W    = 2 * SLOT_W;
    localparam int               BIT_W      = utils::clogb2(FRAME_W);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] RIGHT_BASE = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W);

    logic fall_tick;

    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              lrck_q, lrck_d;
    logic              data_q, data_d;
    logic              fs_q, fs_d;
    logic [7:0]        underrun_q, underrun_d;
    logic              buf_full_q, buf_full_d;
    logic              primed_q, primed_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;

    logic [BIT_W-1:0]  bit_nxt;
    logic [BIT_W-1:0]  slot_pos;
    logic              in_right;
    logic              bit_on;
    logic [DATA_W-1:0] chan;
    logic [DATA_W-1:0] chan_sh;

    i2s_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck (
        .clk       (AUDIO_CLK),
        .rst_n     (iRST_N),
        .bck       (AUD_BCK),
        .fall_tick (fall_tick)
    );

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        lrck_d     = lrck_q;
        data_d     = data_q;
        fs_d       = 1'b0;
        underrun_d = underrun_q;
        buf_full_d = buf_full_q;
        primed_d   = primed_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        frame_l_d  = frame_l_q;
        frame_r_d  = frame_r_q;

        bit_nxt  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
        in_right = (bit_nxt >= RIGHT_BASE);
        slot_pos = in_right ? bit_nxt - RIGHT_BASE : bit_nxt;
        chan     = in_right ? frame_r_q : frame_l_q;
        // Slot position k carries chan[DATA_W-k]; bring that bit down to bit 0.
        chan_sh  = chan >> (DATA_LAST - slot_pos);
        bit_on   = (slot_pos != '0) && (slot_pos <= DATA_LAST);

        if (fall_tick) begin
            bit_cnt_d = bit_nxt;
            lrck_d    = in_right;
            data_d    = bit_on & chan_sh[0];
            if (bit_nxt == '0) begin
                fs_d = 1'b1;
                if (buf_full_q) begin
                    frame_l_d  = hold_l_q;
                    frame_r_d  = hold_r_q;
                    buf_full_d = 1'b0;
                    primed_d   = 1'b1;
                end else if (primed_q && underrun_q != UNDERRUN_MAX) begin
                    underrun_d = underrun_q + 8'd1;
                end
            end
        end

        // An accept only happens with the buffer empty, so it never races a load.
        if (smp.sample_valid && !buf_full_q) begin
            hold_l_d   = smp.lsample;
            hold_r_d   = smp.rsample;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge AUDIO_CLK) begin
        if (!iRST_N) begin
            bit_cnt_q  <= BIT_LAST;
            lrck_q     <= 1'b0;
            data_q     <= 1'b0;
            fs_q       <= 1'b0;
            underrun_q <= '0;
            buf_full_q <= 1'b0;
            primed_q   <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            frame_l_q  <= '0;
            frame_r_q  <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            lrck_q     <= lrck_d;
            data_q     <= data_d;
            fs_q       <= fs_d;
            underrun_q <= underrun_d;
            buf_full_q <= buf_full_d;
            primed_q   <= primed_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            frame_l_q  <= frame_l_d;
            frame_r_q  <= frame_r_d;
        end
    end

    assign smp.sample_ready = !buf_full_q;
    assign AUD_LRCK         = lrck_q;
    assign AUD_DATA         = data_q;
    assign frame_start      = fs_q;
    assign underrun_cnt     = underrun_q;

endmodule
